// File: rtl/keycode_pkg.sv
// Shared constants, state and direction encodings for the keyboard front end.
package keycode_pkg;

  localparam int unsigned CODE_W = 8;
  localparam int unsigned DIR_W  = 4;

  localparam logic [CODE_W-1:0] KEY_NONE = 8'h00;
  localparam logic [CODE_W-1:0] KEY_W    = 8'h1A;
  localparam logic [CODE_W-1:0] KEY_A    = 8'h04;
  localparam logic [CODE_W-1:0] KEY_S    = 8'h16;
  localparam logic [CODE_W-1:0] KEY_D    = 8'h07;

  // Bit positions inside the {up, down, left, right} direction vector
  localparam int unsigned DIR_UP    = 3;
  localparam int unsigned DIR_DOWN  = 2;
  localparam int unsigned DIR_LEFT  = 1;
  localparam int unsigned DIR_RIGHT = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HELD   = 2'd1,
    REPEAT = 2'd2
  } kf_state_t;

  typedef struct packed {
    logic press;
    logic rel;
    logic rpt;
  } kf_pulse_t;

  function automatic logic [DIR_W-1:0] decode_dir(input logic [CODE_W-1:0] code);
    logic [DIR_W-1:0] d;
    d = '0;
    case (code)
      KEY_W:   d[DIR_UP]    = 1'b1;
      KEY_S:   d[DIR_DOWN]  = 1'b1;
      KEY_A:   d[DIR_LEFT]  = 1'b1;
      KEY_D:   d[DIR_RIGHT] = 1'b1;
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/keycode_debounce.sv
// Registers the raw keycode and reports when one value has held for STABLE_CYCLES.
module keycode_debounce
  import keycode_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 1024
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [CODE_W-1:0] keycode_in,
  output logic [CODE_W-1:0] stable_code,
  output logic              stable
);

  localparam int unsigned       CNT_W   = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [CODE_W-1:0] kq;
  logic [CODE_W-1:0] cand;
  logic [CNT_W-1:0]  cnt;

  // Any change of the sampled code restarts the count; otherwise count up and hold at the top
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      kq   <= KEY_NONE;
      cand <= KEY_NONE;
      cnt  <= '0;
    end else begin
      kq <= keycode_in;
      if (kq != cand) begin
        cand <= kq;
        cnt  <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign stable_code = cand;
  assign stable      = (kq == cand) && (cnt == CNT_MAX);

endmodule

// File: rtl/keycode_filter.sv
// Debounced keycode with frame-aligned press/release/auto-repeat pulses and WASD decode.
module keycode_filter
  import keycode_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned REPEAT_DELAY  = 30,
  parameter int unsigned REPEAT_RATE   = 6
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] keycode_in,
  input  logic       vs,
  output logic [7:0] key_code,
  output logic [3:0] dir,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       repeat_pulse,
  output logic       frame_tick
);

  localparam int unsigned FCNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned FCNT_W   = $clog2(FCNT_MAX + 1);
  localparam logic [FCNT_W-1:0] DELAY_CNT = FCNT_W'(REPEAT_DELAY);
  localparam logic [FCNT_W-1:0] RATE_CNT  = FCNT_W'(REPEAT_RATE);

  logic [CODE_W-1:0] stable_code;
  logic              stable;

  keycode_debounce #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_debounce (
    .Clk        (Clk),
    .Reset      (Reset),
    .keycode_in (keycode_in),
    .stable_code(stable_code),
    .stable     (stable)
  );

  kf_state_t         state_q, state_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d, fcnt_inc_c;
  logic              vs_q, vs_q2;
  logic              tick_c;
  logic              commit_c;
  logic [CODE_W-1:0] key_d;
  logic [DIR_W-1:0]  dir_d;
  kf_pulse_t         pulse_d;

  assign tick_c     = vs_q & ~vs_q2;
  assign commit_c   = stable && (stable_code != key_code);
  assign fcnt_inc_c = fcnt_q + FCNT_W'(1);

  // State, counters and every output register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vs_q          <= 1'b1;
      vs_q2         <= 1'b1;
      frame_tick    <= 1'b0;
      state_q       <= IDLE;
      fcnt_q        <= '0;
      key_code      <= KEY_NONE;
      dir           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      vs_q          <= vs;
      vs_q2         <= vs_q;
      frame_tick    <= tick_c;
      state_q       <= state_d;
      fcnt_q        <= fcnt_d;
      key_code      <= key_d;
      dir           <= dir_d;
      press_pulse   <= pulse_d.press;
      release_pulse <= pulse_d.rel;
      repeat_pulse  <= pulse_d.rpt;
    end
  end

  // A commit takes priority over a coincident frame tick, so repeat never overlaps press/release
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    key_d   = key_code;
    dir_d   = dir;
    pulse_d = '0;

    if (commit_c) begin
      key_d         = stable_code;
      dir_d         = decode_dir(stable_code);
      pulse_d.press = (stable_code != KEY_NONE);
      pulse_d.rel   = (key_code != KEY_NONE);
      fcnt_d        = '0;
      state_d       = (stable_code != KEY_NONE) ? HELD : IDLE;
    end else if (frame_tick) begin
      unique case (state_q)
        HELD: begin
          if (fcnt_inc_c == DELAY_CNT) begin
            pulse_d.rpt = 1'b1;
            fcnt_d      = '0;
            state_d     = REPEAT;
          end else begin
            fcnt_d = fcnt_inc_c;
          end
        end
        REPEAT: begin
          if (fcnt_inc_c == RATE_CNT) begin
            pulse_d.rpt = 1'b1;
            fcnt_d      = '0;
          end else begin
            fcnt_d = fcnt_inc_c;
          end
        end
        default: begin
          fcnt_d = fcnt_q;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keycode_filter.sv
// Bench for keycode_filter: directed scenarios plus random key traffic against a sliding-window model.
module tb_keycode_filter;

  localparam int S         = 4;
  localparam int RD        = 3;
  localparam int RR        = 2;
  localparam int VS_PERIOD = 20;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [7:0] keycode_in;
  logic       vs;
  logic [7:0] key_code;
  logic [3:0] dir;
  logic       press_pulse, release_pulse, repeat_pulse, frame_tick;

  always #5 Clk = ~Clk;

  keycode_filter #(
    .STABLE_CYCLES(S),
    .REPEAT_DELAY (RD),
    .REPEAT_RATE  (RR)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .keycode_in   (keycode_in),
    .vs           (vs),
    .key_code     (key_code),
    .dir          (dir),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .repeat_pulse (repeat_pulse),
    .frame_tick   (frame_tick)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int vcnt     = 1;

  // Reference model: a code is accepted once the last S+1 sampled inputs agree
  logic [7:0] m_run_val, m_key;
  int         m_run_len;
  logic       m_v1, m_v2, m_ft, m_press, m_rel, m_rep;
  logic [3:0] m_dir;
  int         m_n;

  function automatic logic [3:0] exp_dir(input logic [7:0] c);
    case (c)
      8'h1A:   return 4'b1000;
      8'h16:   return 4'b0100;
      8'h04:   return 4'b0010;
      8'h07:   return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic model_reset();
    m_run_val = 8'h00; m_run_len = 0;
    m_v1 = 1'b1; m_v2 = 1'b1; m_ft = 1'b0;
    m_key = 8'h00; m_dir = 4'b0000;
    m_press = 1'b0; m_rel = 1'b0; m_rep = 1'b0; m_n = 0;
  endtask

  task automatic model_edge();
    logic commit, ft_new;
    commit = (m_run_len >= S + 1) && (m_run_val != m_key);
    ft_new = m_v1 & ~m_v2;
    m_press = 1'b0; m_rel = 1'b0; m_rep = 1'b0;
    if (commit) begin
      m_rel   = (m_key != 8'h00);
      m_press = (m_run_val != 8'h00);
      m_key   = m_run_val;
      m_dir   = exp_dir(m_run_val);
      m_n     = 0;
    end else if (m_key != 8'h00 && m_ft) begin
      m_n   = m_n + 1;
      m_rep = (m_n == RD) || (m_n > RD && ((m_n - RD) % RR) == 0);
    end
    m_ft = ft_new;
    m_v2 = m_v1;
    m_v1 = vs;
    if (keycode_in == m_run_val) begin
      if (m_run_len < 1000) m_run_len = m_run_len + 1;
    end else begin
      m_run_val = keycode_in;
      m_run_len = 1;
    end
  endtask

  // Apply inputs for one cycle; on return the outputs of that edge are settled
  task automatic step(input logic [7:0] k);
    keycode_in = k;
    vs         = (vcnt != 0);
    vcnt       = (vcnt + 1) % VS_PERIOD;
    @(posedge Clk);
    if (Reset) model_reset();
    else model_edge();
    @(negedge Clk);
  endtask

  task automatic test_reset();
    Reset = 1'b1; keycode_in = 8'h00; vs = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if ({key_code, dir, press_pulse, release_pulse, repeat_pulse, frame_tick} !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h exp=0000", {key_code, dir, press_pulse, release_pulse, repeat_pulse, frame_tick});
    end
    for (int i = 0; i < 3; i++) step(8'h00);
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(8'h00);
      n_checks++;
      if ({key_code, dir, press_pulse, release_pulse, repeat_pulse, frame_tick} !== {m_key, m_dir, m_press, m_rel, m_rep, m_ft}) begin
        n_fail++;
        $display("FAIL reset_idle got=%h exp=%h", {key_code, dir, press_pulse, release_pulse, repeat_pulse, frame_tick}, {m_key, m_dir, m_press, m_rel, m_rep, m_ft});
      end
    end
  endtask

  task automatic test_basic_press();
    int rel_seen = 0;
    for (int i = 1; i <= 8; i++) begin
      step(8'h1A);
      n_checks++;
      if (press_pulse !== (i == 6)) begin
        n_fail++;
        $display("FAIL basic_press_timing edge=%0d got=%b exp=%b", i, press_pulse, (i == 6));
      end
      if (i == 6) begin
        n_checks++;
        if (key_code !== 8'h1A || dir !== 4'b1000) begin
          n_fail++;
          $display("FAIL basic_press_code got=%h/%b exp=1a/1000", key_code, dir);
        end
      end
    end
    for (int i = 0; i < 12; i++) begin
      step(8'h00);
      if (release_pulse) rel_seen++;
      n_checks++;
      if ({key_code, dir, press_pulse, release_pulse, repeat_pulse, frame_tick} !== {m_key, m_dir, m_press, m_rel, m_rep, m_ft}) begin
        n_fail++;
        $display("FAIL basic_release got=%h exp=%h", {key_code, dir, press_pulse, release_pulse, repeat_pulse, frame_tick}, {m_key, m_dir, m_press, m_rel, m_rep, m_ft});
      end
    end
    n_checks++;
    if (rel_seen != 1 || key_code !== 8'h00) begin
      n_fail++;
      $display("FAIL basic_release_count got=%0d/%h exp=1/00", rel_seen, key_code);
    end
  endtask

  task automatic test_glitch();
    int pulses = 0;
    for (int i = 0; i < 15; i++) begin
      step(i < 3 ? 8'h07 : 8'h00);
      if (press_pulse || release_pulse || repeat_pulse) pulses++;
      n_checks++;
      if ({key_code, dir, press_pulse, release_pulse, repeat_pulse, frame_tick} !== {m_key, m_dir, m_press, m_rel, m_rep, m_ft}) begin
        n_fail++;
        $display("FAIL glitch_cycle got=%h exp=%h", {key_code, dir, press_pulse, release_pulse, repeat_pulse, frame_tick}, {m_key, m_dir, m_press, m_rel, m_rep, m_ft});
      end
    end
    n_checks++;
    if (pulses != 0 || key_code !== 8'h00) begin
      n_fail++;
      $display("FAIL glitch_reject got pulses=%0d key=%h exp pulses=0 key=00", pulses, key_code);
    end
  endtask

  task automatic test_auto_repeat();
    bit counting = 0;
    int idx = 0, reps = 0, presses = 0, rels = 0;
    for (int i = 0; i < 160; i++) begin
      step(8'h04);
      n_checks++;
      if ({key_code, dir, press_pulse, release_pulse, repeat_pulse, frame_tick} !== {m_key, m_dir, m_press, m_rel, m_rep, m_ft}) begin
        n_fail++;
        $display("FAIL repeat_cycle got=%h exp=%h", {key_code, dir, press_pulse, release_pulse, repeat_pulse, frame_tick}, {m_key, m_dir, m_press, m_rel, m_rep, m_ft});
      end
      if (press_pulse) begin presses++; counting = 1; idx = 0; end
      if (release_pulse) rels++;
      if (repeat_pulse) begin
        reps++;
        n_checks++;
        if (!(idx == RD || (idx > RD && ((idx - RD) % RR) == 0))) begin
          n_fail++;
          $display("FAIL repeat_tick_index got=%0d exp=3,5,7..", idx);
        end
      end
      if (counting && m_ft) idx++;
    end
    n_checks++;
    if (presses != 1 || rels != 0 || reps < 3 || dir !== 4'b0010) begin
      n_fail++;
      $display("FAIL repeat_summary got p=%0d r=%0d rep=%0d dir=%b exp p=1 r=0 rep>=3 dir=0010", presses, rels, reps, dir);
    end
    for (int i = 0; i < 10; i++) step(8'h00);
  endtask

  task automatic test_key_change();
    int both = 0;
    for (int i = 0; i < 10; i++) step(8'h1A);
    for (int i = 0; i < 90; i++) begin
      step(8'h16);
      if (press_pulse && release_pulse) both++;
      n_checks++;
      if ({key_code, dir, press_pulse, release_pulse, repeat_pulse, frame_tick} !== {m_key, m_dir, m_press, m_rel, m_rep, m_ft}) begin
        n_fail++;
        $display("FAIL change_cycle got=%h exp=%h", {key_code, dir, press_pulse, release_pulse, repeat_pulse, frame_tick}, {m_key, m_dir, m_press, m_rel, m_rep, m_ft});
      end
    end
    n_checks++;
    if (both != 1 || dir !== 4'b0100) begin
      n_fail++;
      $display("FAIL change_pulses got both=%0d dir=%b exp both=1 dir=0100", both, dir);
    end
    for (int i = 0; i < 10; i++) step(8'h00);
  endtask

  task automatic test_tick_coincide();
    int idx = 0, first = -1;
    bit counting = 0;
    for (int i = 0; i < 10; i++) step(8'h00);
    vcnt = 18;
    for (int i = 1; i <= 90; i++) begin
      step(8'h1A);
      if (i == 5) begin
        n_checks++;
        if (frame_tick !== 1'b1) begin
          n_fail++;
          $display("FAIL coincide_tick_align got=%b exp=1", frame_tick);
        end
      end
      if (i == 6) begin
        n_checks++;
        if (press_pulse !== 1'b1 || repeat_pulse !== 1'b0) begin
          n_fail++;
          $display("FAIL coincide_press got p=%b rep=%b exp p=1 rep=0", press_pulse, repeat_pulse);
        end
      end
      n_checks++;
      if ({key_code, dir, press_pulse, release_pulse, repeat_pulse, frame_tick} !== {m_key, m_dir, m_press, m_rel, m_rep, m_ft}) begin
        n_fail++;
        $display("FAIL coincide_cycle got=%h exp=%h", {key_code, dir, press_pulse, release_pulse, repeat_pulse, frame_tick}, {m_key, m_dir, m_press, m_rel, m_rep, m_ft});
      end
      if (press_pulse) begin counting = 1; idx = 0; end
      if (repeat_pulse && first < 0) first = idx;
      if (counting && m_ft) idx++;
    end
    n_checks++;
    if (first != RD) begin
      n_fail++;
      $display("FAIL coincide_first_repeat got tick=%0d exp=%0d", first, RD);
    end
    for (int i = 0; i < 10; i++) step(8'h00);
  endtask

  task automatic test_reset_while_held();
    for (int i = 0; i < 10; i++) step(8'h07);
    Reset = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if ({key_code, dir, press_pulse, release_pulse, repeat_pulse, frame_tick} !== 16'h0000) begin
      n_fail++;
      $display("FAIL held_reset_outputs got=%h exp=0000", {key_code, dir, press_pulse, release_pulse, repeat_pulse, frame_tick});
    end
    for (int i = 0; i < 3; i++) step(8'h07);
    Reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step(8'h07);
      n_checks++;
      if (press_pulse !== (i == 6)) begin
        n_fail++;
        $display("FAIL held_reset_press edge=%0d got=%b exp=%b", i, press_pulse, (i == 6));
      end
      if (i == 6) begin
        n_checks++;
        if (key_code !== 8'h07 || dir !== 4'b0001) begin
          n_fail++;
          $display("FAIL held_reset_code got=%h/%b exp=07/0001", key_code, dir);
        end
      end
    end
    for (int i = 0; i < 10; i++) step(8'h00);
  endtask

  task automatic test_random();
    logic [7:0] codes [6];
    logic [7:0] k;
    int len;
    codes[0] = 8'h00; codes[1] = 8'h1A; codes[2] = 8'h16;
    codes[3] = 8'h04; codes[4] = 8'h07; codes[5] = 8'h2C;
    for (int seg = 0; seg < 50; seg++) begin
      k   = codes[$urandom_range(0, 5)];
      len = $urandom_range(1, 40);
      if ($urandom_range(0, 9) == 0) begin
        Reset = 1'b1;
        model_reset();
        step(k);
        step(k);
        Reset = 1'b0;
      end
      for (int i = 0; i < len; i++) begin
        step(k);
        n_checks++;
        if ({key_code, dir, press_pulse, release_pulse, repeat_pulse, frame_tick} !== {m_key, m_dir, m_press, m_rel, m_rep, m_ft}) begin
          n_fail++;
          $display("FAIL random_cycle seg=%0d got=%h exp=%h", seg, {key_code, dir, press_pulse, release_pulse, repeat_pulse, frame_tick}, {m_key, m_dir, m_press, m_rel, m_rep, m_ft});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_press();
    test_glitch();
    test_auto_repeat();
    test_key_change();
    test_tick_coincide();
    test_reset_while_held();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keycode_filter.md
# keycode_filter

Conditions the raw 8-bit USB keycode exported by the Nios II system before the ball and game logic consume it. It debounces keycode changes and emits one-cycle press, release and auto-repeat pulses aligned to the VGA frame. It also decodes the WASD movement keys into a registered direction vector. It sits between the `keycode_export` PIO of the Nios system and the frame-driven motion blocks, and runs on the 50 MHz system clock.

## Interface
Parameters:
- `STABLE_CYCLES`, default 1024: number of Clk cycles a new keycode must hold before it is accepted; must be ≥ 2.
- `REPEAT_DELAY`, default 30: number of frames a key must be held before the first repeat pulse; must be ≥ 1.
- `REPEAT_RATE`, default 6: number of frames between later repeat pulses; must be ≥ 1.

Ports:
- `Clk` in 1: 50 MHz system clock; the only clock.
- `Reset` in 1: asynchronous, active-high reset.
- `keycode_in` in 8: raw keycode from the Nios PIO; 0x00 means no key.
- `vs` in 1: vertical sync from `vga_controller`, active low, synchronous to Clk.
- `key_code` out 8: debounced code of the key currently held; 0x00 when no key is held.
- `dir` out 4: {up, down, left, right}; decoded from `key_code`.
- `press_pulse` out 1: one-cycle pulse when a new nonzero code is accepted.
- `release_pulse` out 1: one-cycle pulse when a held code is dropped.
- `repeat_pulse` out 1: one-cycle auto-repeat strobe.
- `frame_tick` out 1: one-cycle pulse on each rising edge of `vs`.

## Operation
- **Input registers.** `keycode_in` is registered into `kq`. `vs` is registered twice (`vs_q`, `vs_q2`). `frame_tick` = `vs_q & ~vs_q2`.
- **Debounce.**
  - Candidate register `cand` with counter `cnt`.
  - If `kq != cand`: `cand <= kq` and `cnt <= 0`.
  - Otherwise `cnt` increments and saturates at `STABLE_CYCLES-1`.
- **Commit.** A commit occurs when `kq == cand`, `cnt == STABLE_CYCLES-1` and `cand != key_code`. On commit, `key_code <= cand` and:
  - old code 0, new code nonzero: `press_pulse`.
  - old code nonzero, new code 0: `release_pulse`.
  - both codes nonzero and different: `release_pulse` and `press_pulse` in the same cycle.
- **FSM states.**
  - IDLE: `key_code` is 0.
  - HELD: key accepted, waiting for the first repeat.
  - REPEAT: key held, repeating.
- **FSM transitions.**
  - Any commit to a nonzero code goes to HELD and clears the frame counter `fcnt`.
  - A commit to 0 goes to IDLE.
  - In HELD, each `frame_tick` increments `fcnt`. When the incremented value equals `REPEAT_DELAY`: `repeat_pulse`, go to REPEAT, `fcnt <= 0`.
  - In REPEAT, each `frame_tick` increments `fcnt`. When the incremented value equals `REPEAT_RATE`: `repeat_pulse`, `fcnt <= 0`.
  - `frame_tick` is ignored in IDLE.
- **Direction decode.**
  - `dir` is registered and updated on the same edge as `key_code`.
  - 0x1A (W) → 4'b1000; 0x16 (S) → 4'b0100; 0x04 (A) → 4'b0010; 0x07 (D) → 4'b0001.
  - Any other code → 4'b0000.
- **Width rules.**
  - `cnt` is $clog2(`STABLE_CYCLES`) bits.
  - `fcnt` is $clog2(max(`REPEAT_DELAY`, `REPEAT_RATE`)+1) bits.
  - Neither counter wraps.

## Timing
- **Reset values.** Every output is 0; state is IDLE; `kq`, `cand`, `cnt` and `fcnt` are 0; `vs_q` and `vs_q2` are 1.
- **Commit latency.** When `keycode_in` changes and then holds steady, the commit registers on the (`STABLE_CYCLES`+2)th rising Clk edge after the change. `key_code`, `dir` and the pulses update together on that edge.
- **Glitches.** A change shorter than `STABLE_CYCLES` cycles produces no pulse and no `key_code` change. A return to the old value restarts the count with no effect.
- **Commit coinciding with a frame tick.** The commit wins: `fcnt` is cleared and that tick is not counted. `repeat_pulse` is never asserted in the same cycle as `press_pulse` or `release_pulse`.
- **`frame_tick` delay.** `frame_tick` is asserted 2 cycles after `vs` rises.
- **Reset during operation.** Reset clears all state immediately. If a key is still held when Reset is released, a fresh `press_pulse` follows after the commit latency.

## Structure
- **Package `keycode_pkg`:**
  - `KEY_NONE`, `KEY_W`, `KEY_A`, `KEY_S`, `KEY_D` constants.
  - `kf_state_t` enum {IDLE, HELD, REPEAT}.
  - `dir_t` bit positions.
- **Sub-module `keycode_debounce`:** contains `kq`, `cand` and `cnt`, and outputs `stable_code` and a `stable` flag. Commit detection, the FSM, the frame logic and the decode stay in `keycode_filter`.

## Test plan
All scenarios use `STABLE_CYCLES`=4, `REPEAT_DELAY`=3, `REPEAT_RATE`=2, and a `vs` low pulse every 20 cycles.
- **Basic press.** `keycode_in`=0x1A held from cycle 10 → `key_code`=0x1A, `dir`=4'b1000 and a single `press_pulse` on the 6th edge after cycle 10.
- **Glitch rejection.** 0x07 for 3 cycles, then back to 0 → no pulses, `key_code` stays 0x00.
- **Auto-repeat.** Hold 0x04 → `repeat_pulse` on the 3rd `frame_tick` after the press, then on every 2nd tick. No other pulses; `dir`=4'b0010.
- **Key change.** Switch 0x1A → 0x16 directly → `press_pulse` and `release_pulse` in one cycle, `dir`=4'b0100, repeat count restarts.
- **Commit and tick coincide.** Align `frame_tick` with the commit cycle → that tick is not counted; first repeat on the 3rd later tick.
- **Reset while held.** Assert Reset while 0x07 is held → all outputs are 0 during reset; after release, `press_pulse` 6 edges later with `key_code`=0x07.
